// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller.
//   state_t     : controller FSM state encoding (IDLE/ISSUE/WAIT/RESP)
//   OPW_DEF     : default operand width; product width is 2*OPW
//   TIMEOUT_DEF : default watchdog limit in WAIT cycles
//   cnt_width() : width of a counter that runs 0..limit-1
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int OPW_DEF     = 8;
    localparam int PW_DEF      = 2 * OPW_DEF;
    localparam int TIMEOUT_DEF = 16;

    function automatic int cnt_width(input int limit);
        return (limit < 3) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request searching upward
// from ptr_i with wrap-around.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester
//   any_o   : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW:0]   pos;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // one extra bit so ptr + offset cannot overflow before the wrap
            pos = {1'b0, ptr_i} + (IW+1)'(i);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            cand = pos[IW-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential signed multiplier among NREQ requesters.
// One operation in flight: IDLE (arbitrate) -> ISSUE (start pulse) ->
// WAIT (completion or watchdog) -> RESP (hold result until accepted).
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester request handshake, one-hot grant
//   req_a/req_b             : packed signed operands, requester i at [i*OPW +: OPW]
//   rsp_valid/rsp_ready     : per-requester response handshake, one-hot valid
//   rsp_product/rsp_err     : shared result bus; err=1 means watchdog abort, product 0
//   mul_start/mul_a/mul_b   : to the multiplier
//   mul_product/mul_ready   : from the multiplier
//   busy                    : controller not in IDLE
//   err_timeout             : sticky watchdog flag, cleared only by reset
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPW-1:0]   req_a,
    input  logic [NREQ*OPW-1:0]   req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*OPW-1:0]      rsp_product,
    output logic                  rsp_err,
    output logic                  mul_start,
    output logic [OPW-1:0]        mul_a,
    output logic [OPW-1:0]        mul_b,
    input  logic [2*OPW-1:0]      mul_product,
    input  logic                  mul_ready,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int PW = 2 * OPW;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = cnt_width(TIMEOUT);

    state_t                 state_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [IW-1:0]          rr_ptr_d;
    logic [IW-1:0]          owner_q;
    logic signed [OPW-1:0]  a_q;
    logic signed [OPW-1:0]  b_q;
    logic signed [PW-1:0]   prod_q;
    logic                   err_q;
    logic                   err_timeout_q;
    logic [CW-1:0]          wait_cnt_q;

    logic [NREQ-1:0]        gnt;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic signed [OPW-1:0]  sel_a_d;
    logic signed [OPW-1:0]  sel_b_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        sel_a_d = '0;
        sel_b_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a_d = req_a[i*OPW +: OPW];
                sel_b_d = req_b[i*OPW +: OPW];
            end
        end
    end

    assign rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            prod_q        <= '0;
            err_q         <= 1'b0;
            err_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        owner_q  <= gnt_idx;
                        a_q      <= sel_a_d;
                        b_q      <= sel_b_d;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // mul_ready is only trusted here: it is stale during the start cycle
                    if (mul_ready) begin
                        prod_q  <= mul_product;
                        err_q   <= 1'b0;
                        state_q <= ST_RESP;
                    end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        prod_q        <= '0;
                        err_q         <= 1'b1;
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner_q]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Grant is combinational in IDLE; forced low while reset is held
    assign req_ready   = (rst_n && state_q == ST_IDLE) ? gnt : '0;
    assign rsp_valid   = (state_q == ST_RESP) ? (NREQ'(1) << owner_q) : '0;
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;
    assign mul_start   = (state_q == ST_ISSUE);
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
module tb_mult_share_ctrl;

    localparam int NREQ    = 4;
    localparam int OPW     = 8;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [15:0]       rsp_product;
    logic              rsp_err;
    logic              mul_start;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_product;
    logic              mul_ready;
    logic              busy;
    logic              err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          owner;
        logic [15:0] prod;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    mult_share_ctrl #(
        .NREQ    (NREQ),
        .OPW     (OPW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_ready   (mul_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: ready rises in the 9th cycle after the start cycle and
    // then stays high (stale) until the next start; powers up with junk.
    bit          stub_stall = 1'b0;
    int          m_cnt      = 0;
    bit          m_hang     = 1'b0;
    logic [15:0] m_res;
    logic signed [15:0] m_tmp;
    initial begin
        mul_ready   = 1'b1;
        mul_product = 16'h5A5A;
        m_res       = 16'h0;
    end
    always @(negedge clk) begin
        if (mul_start) begin
            m_tmp  = $signed(mul_a) * $signed(mul_b);
            m_res  = m_tmp;
            m_cnt  = 9;
            m_hang = stub_stall;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 8) mul_ready = 1'b0;
            if (m_cnt == 0 && !m_hang) begin
                mul_ready   = 1'b1;
                mul_product = m_res;
            end
        end
    end

    // Scoreboard: push on grant, pop on response handshake; grant invariants.
    logic signed [7:0]  sb_a, sb_b;
    logic signed [15:0] sb_p;
    exp_t               sb_e;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (req_ready != 0) begin
                total++;
                if ($countones(req_ready) != 1 || busy !== 1'b0 || (req_ready & ~req_valid) != 0) begin
                    bad++;
                    $display("FAIL grant_onehot: req_ready=%b busy=%b req_valid=%b, required single granted bit in IDLE", req_ready, busy, req_valid);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        sb_a = req_a[i*8 +: 8];
                        sb_b = req_b[i*8 +: 8];
                        sb_p = sb_a * sb_b;
                        sb_e.owner = i;
                        sb_e.prod  = stub_stall ? 16'h0000 : sb_p;
                        sb_e.err   = stub_stall;
                        exp_q.push_back(sb_e);
                    end
                end
            end
            if ((rsp_valid & rsp_ready) != 0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: rsp_valid=%b product=%h, required no response", rsp_valid, rsp_product);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (rsp_valid !== (4'b0001 << sb_e.owner) || rsp_product !== sb_e.prod || rsp_err !== sb_e.err) begin
                        bad++;
                        $display("FAIL sb_response: valid=%b product=%h err=%b, required valid=%b product=%h err=%b",
                                 rsp_valid, rsp_product, rsp_err, 4'b0001 << sb_e.owner, sb_e.prod, sb_e.err);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One request from requester who; returns what came back and timing.
    task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output logic err,
                          output int t_acc, output int t_rsp, output int n_start, output bit ok);
        bit acc;
        ok = 0; acc = 0; n_start = 0; t_acc = 0; t_rsp = 0; prod = '0; err = 1'b0;
        @(negedge clk);
        req_a[who*8 +: 8] = a;
        req_b[who*8 +: 8] = b;
        req_valid = 4'b0001 << who;
        rsp_ready = 4'hF;
        for (int k = 0; k < 60; k++) begin
            #2;
            if (!acc && req_ready[who]) begin acc = 1; t_acc = cyc; end
            if (mul_start) n_start++;
            if (rsp_valid != 0) begin
                prod = rsp_product; err = rsp_err; t_rsp = cyc; ok = 1;
            end
            @(negedge clk);
            if (acc) req_valid = '0;
            if (ok) break;
        end
        req_valid = '0;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        rsp_ready = 4'hF;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #2;
            if (!busy && rsp_valid == 0) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 4'hF;
        #2;
        total++;
        if ({req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy, err_timeout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b prod=%h err=%b start=%b a=%h b=%h busy=%b to=%b, required all 0",
                     req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy, err_timeout);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [15:0] p; logic e; int ta, tr, ns; bit ok;
        run_op(0, 8'd3, 8'hFB, p, e, ta, tr, ns, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_done: no response, required response"); end
        total++;
        if (tr - ta !== 11) begin bad++; $display("FAIL single_latency: got %0d, required 11", tr - ta); end
        total++;
        if (ns !== 1) begin bad++; $display("FAIL single_start_pulses: got %0d, required 1", ns); end
        total++;
        if (p !== 16'hFFF1 || e !== 1'b0) begin
            bad++; $display("FAIL single_product: got %h err=%b, required fff1 err=0", p, e);
        end
    endtask

    task automatic test_round_robin();
        int gidx[5]; int gcyc[5]; int ng; bit ok;
        do_reset();
        @(negedge clk);
        req_a = {8'd4, 8'd3, 8'd2, 8'd1};
        req_b = {8'd2, 8'd2, 8'd2, 8'd2};
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        ng = 0;
        for (int k = 0; k < 100 && ng < 5; k++) begin
            #2;
            if (req_ready != 0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx[ng] = i;
                gcyc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        total++;
        if (ng !== 5) begin bad++; $display("FAIL rr_grant_count: got %0d, required 5", ng); end
        for (int i = 0; i < ng; i++) begin
            total++;
            if (gidx[i] !== i % 4) begin bad++; $display("FAIL rr_order[%0d]: got %0d, required %0d", i, gidx[i], i % 4); end
            if (i > 0) begin
                total++;
                if (gcyc[i] - gcyc[i-1] !== 12) begin
                    bad++; $display("FAIL rr_gap[%0d]: got %0d, required 12", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_drain: still busy, required idle"); end
    endtask

    task automatic test_corners();
        int          who[3] = '{2, 1, 3};
        logic [7:0]  ca[3]  = '{8'h80, 8'h80, 8'h00};
        logic [7:0]  cb[3]  = '{8'h80, 8'h7F, 8'hFF};
        logic [15:0] ce[3]  = '{16'h4000, 16'hC080, 16'h0000};
        logic [15:0] p; logic e; int ta, tr, ns; bit ok;
        for (int i = 0; i < 3; i++) begin
            run_op(who[i], ca[i], cb[i], p, e, ta, tr, ns, ok);
            total++;
            if (!ok || p !== ce[i] || e !== 1'b0) begin
                bad++; $display("FAIL corner[%0d]: got %h err=%b ok=%0d, required %h err=0", i, p, e, ok, ce[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, seen, ok;
        acc = 0; seen = 0;
        @(negedge clk);
        req_a[1*8 +: 8] = 8'd5;  req_b[1*8 +: 8] = 8'd6;
        req_a[2*8 +: 8] = 8'd2;  req_b[2*8 +: 8] = 8'hFD;
        req_valid = 4'b0010;
        rsp_ready = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (req_ready[1]) acc = 1;
            if (rsp_valid != 0) begin seen = 1; break; end
            @(negedge clk);
            if (acc) req_valid = 4'b0100;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_response: none, required rsp_valid"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_ready = 4'b1101;
            #2;
            total++;
            if (rsp_valid !== 4'b0010 || rsp_product !== 16'd30 || busy !== 1'b1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold[%0d]: valid=%b prod=%h busy=%b ready=%b, required 0010 001e 1 0000",
                                k, rsp_valid, rsp_product, busy, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 4'hF;
        @(negedge clk);
        #2;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_next_grant: got %b, required 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_drain: still busy, required idle"); end
    endtask

    task automatic test_timeout();
        logic [15:0] p; logic e; int ta, tr, ns; bit ok;
        stub_stall = 1'b1;
        run_op(3, 8'd9, 8'd9, p, e, ta, tr, ns, ok);
        stub_stall = 1'b0;
        total++;
        if (!ok || p !== 16'h0 || e !== 1'b1) begin
            bad++; $display("FAIL to_response: got %h err=%b ok=%0d, required 0000 err=1", p, e, ok);
        end
        total++;
        if (tr - ta !== TIMEOUT + 2) begin bad++; $display("FAIL to_latency: got %0d, required %0d", tr - ta, TIMEOUT + 2); end
        total++;
        if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b, required 1", err_timeout); end
        run_op(0, 8'd4, 8'hFE, p, e, ta, tr, ns, ok);
        total++;
        if (!ok || p !== 16'hFFF8 || e !== 1'b0 || err_timeout !== 1'b1) begin
            bad++; $display("FAIL to_recover: got %h err=%b sticky=%b, required fff8 err=0 sticky=1", p, e, err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        bit acc; int stray;
        logic [15:0] p; logic e; int ta, tr, ns; bit ok;
        acc = 0;
        @(negedge clk);
        req_a[1*8 +: 8] = 8'd11; req_b[1*8 +: 8] = 8'd3;
        req_valid = 4'b0010;
        rsp_ready = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (req_ready[1]) acc = 1;
            @(negedge clk);
            if (acc) break;
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (!acc || busy !== 1'b1 || mul_a !== 8'd11) begin
            bad++; $display("FAIL rm_inflight: acc=%0d busy=%b a=%h, required 1 1 0b", acc, busy, mul_a);
        end
        req_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy, err_timeout} !== '0) begin
            bad++; $display("FAIL rm_async_clear: ready=%b rvalid=%b prod=%h start=%b a=%h busy=%b to=%b, required all 0",
                            req_ready, rsp_valid, rsp_product, mul_start, mul_a, busy, err_timeout);
        end
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        req_valid = '0;
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #2;
            if (rsp_valid != 0 || busy) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL rm_stale: %0d active cycles, required 0", stray); end
        run_op(2, 8'd7, 8'd7, p, e, ta, tr, ns, ok);
        total++;
        if (!ok || p !== 16'd49 || e !== 1'b0 || tr - ta !== 11) begin
            bad++; $display("FAIL rm_after: got %h err=%b lat=%0d ok=%0d, required 0031 err=0 lat=11", p, e, tr - ta, ok);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_corners();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        @(negedge clk);
        #2;
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: %0d pending, required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
